i_memory: RTL and testbench

I_MEMORY -- requirements
Module: I_MEMORY

---
 rtl/i_memory.sv | 68 ++++++
 tb/tb_i_memory.sv | 127 ++++++++++++
 2 files changed

// File: rtl/i_memory.sv
// i_memory: MEM stage -- data memory, branch resolution and MEM/WB latch; define DMEM_WAIT_EN for a 3-cycle wait-state memory.
module i_memory (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctlout,
    input  logic [2:0]  m_ctlout,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg
);
    logic [31:0] mem_q [256] = '{default: 32'h0};
    logic [7:0]  addr;
    logic        complete;
    logic [1:0]  mem_wb_ctl_q;
    logic [31:0] read_data_q;
    logic [31:0] mem_alu_result_q;
    logic [4:0]  mem_write_reg_q;
    assign addr          = alu_result[9:2];
    assign PCSrc         = ~rst & m_ctlout[2] & zero;
    assign branch_target = add_result;
`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;
    state_t state_q, state_d;
    logic   mem_op;
    assign mem_op = m_ctlout[1] | m_ctlout[0];
    assign stall  = ~rst & (((state_q == IDLE) & mem_op) | (state_q == WAIT1));
    // a memory op walks IDLE -> WAIT1 -> WAIT2 -> IDLE; reset abandons it
    always_comb state_d = rst ? IDLE : (state_q == IDLE) ? (mem_op ? WAIT1 : IDLE) : (state_q == WAIT1) ? WAIT2 : IDLE;
    // wait FSM state register
    always_ff @(posedge clk) state_q <= state_d;
`else
    logic unused_read;
    assign unused_read = m_ctlout[1];
    assign stall       = 1'b0;
`endif
    assign complete = ~rst & ~stall;
    // stores commit only on the completing edge, so an abandoned access never writes
    always_ff @(posedge clk) if (complete && m_ctlout[0]) mem_q[addr] <= rdata2out;
    // MEM/WB latch: bubble while stalled, read-before-write on collision
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_ctl_q     <= 2'b00;
            read_data_q      <= 32'h0;
            mem_alu_result_q <= 32'h0;
            mem_write_reg_q  <= 5'h0;
        end else if (stall) begin
            mem_wb_ctl_q     <= 2'b00;
        end else begin
            mem_wb_ctl_q     <= wb_ctlout;
            read_data_q      <= mem_q[addr];
            mem_alu_result_q <= alu_result;
            mem_write_reg_q  <= five_bit_muxout;
        end
    end
    assign mem_wb_ctl     = mem_wb_ctl_q;
    assign read_data      = read_data_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_write_reg  = mem_write_reg_q;
endmodule

// File: tb/tb_i_memory.sv
// tb_i_memory: randomized check of i_memory against an array-based model of the MEM stage.
module tb_i_memory;
`ifdef DMEM_WAIT_EN
    localparam int STALLS = 2;
`else
    localparam int STALLS = 0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wb_ctlout = '0;
    logic [2:0]  m_ctlout = 3'b100;
    logic [31:0] add_result = '0;
    logic        zero = 1'b1;
    logic [31:0] alu_result = '0;
    logic [31:0] rdata2out = '0;
    logic [4:0]  five_bit_muxout = '0;
    logic        PCSrc, stall;
    logic [31:0] branch_target, read_data, mem_alu_result;
    logic [1:0]  mem_wb_ctl;
    logic [4:0]  mem_write_reg;
    logic [31:0] m_mem [256];
    logic [1:0]  e_ctl = '0;
    logic [31:0] e_rd = '0, e_alu = '0;
    logic [4:0]  e_reg = '0;
    int n_cmp = 0, n_err = 0;

    i_memory dut (
        .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
        .add_result(add_result), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
        .PCSrc(PCSrc), .branch_target(branch_target), .stall(stall),
        .mem_wb_ctl(mem_wb_ctl), .read_data(read_data),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_latch(input string tag);
        check({tag, "_ctl"}, {30'h0, mem_wb_ctl}, {30'h0, e_ctl});
        check({tag, "_rd"}, read_data, e_rd);
        check({tag, "_alu"}, mem_alu_result, e_alu);
        check({tag, "_reg"}, {27'h0, mem_write_reg}, {27'h0, e_reg});
    endtask

    // drives one access (called just after an edge) and checks every cycle of it
    task automatic op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add,
                      input logic z, input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rg);
        int n;
        logic [7:0] w;
        wb_ctlout = wb; m_ctlout = m; add_result = add; zero = z;
        alu_result = alu; rdata2out = data; five_bit_muxout = rg;
        #1;
        check("pcsrc", {31'h0, PCSrc}, {31'h0, m[2] & z});
        check("btgt", branch_target, add);
        n = (m[1] | m[0]) ? STALLS : 0;
        for (int i = 0; i < n; i++) begin
            check("stall_hi", {31'h0, stall}, 32'h1);
            @(posedge clk); #1;
            e_ctl = 2'b00;
            check_latch("bubble");
        end
        check("stall_lo", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        w = alu[9:2];
        e_rd = m_mem[w];
        if (m[0]) m_mem[w] = data;
        e_ctl = wb; e_alu = alu; e_reg = rg;
        check_latch("done");
    endtask

    initial begin
        logic [31:0] r;
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_pcsrc", {31'h0, PCSrc}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check_latch("rst");
`ifdef DMEM_WAIT_EN
        rst = 1'b0;
        wb_ctlout = 2'b10; m_ctlout = 3'b001; alu_result = 32'h20; rdata2out = 32'h5555_AAAA; five_bit_muxout = 5'd3;
        @(posedge clk); #1;
        check("abort_stall", {31'h0, stall}, 32'h1);
        rst = 1'b1; #1;
        check("abort_rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        check_latch("abort");
        rst = 1'b0;
        op(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        op(2'b11, 3'b010, 32'h0, 1'b0, 32'h20, 32'h0, 5'd4);
        check("abort_mem8", read_data, 32'h0);
`else
        rst = 1'b0;
`endif
        op(2'b00, 3'b001, 32'h0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        op(2'b11, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd8);
        check("sl_rd", read_data, 32'hDEADBEEF);
        check("sl_ctl", {30'h0, mem_wb_ctl}, 32'h3);
        check("sl_reg", {27'h0, mem_write_reg}, 32'd8);
        op(2'b00, 3'b100, 32'h40, 1'b1, 32'h0, 32'h0, 5'd0);
        op(2'b00, 3'b100, 32'h40, 1'b0, 32'h0, 32'h0, 5'd0);
        op(2'b00, 3'b001, 32'h0, 1'b0, 32'h400, 32'h1234, 5'd0);
        op(2'b11, 3'b010, 32'h0, 1'b0, 32'h0, 32'h0, 5'd1);
        check("wrap0", read_data, 32'h1234);
        op(2'b11, 3'b010, 32'h0, 1'b0, 32'h403, 32'h0, 5'd1);
        check("wrap403", read_data, 32'h1234);
        op(2'b00, 3'b001, 32'h0, 1'b0, 32'h14, 32'hA, 5'd0);
        op(2'b10, 3'b011, 32'h0, 1'b0, 32'h14, 32'hB, 5'd2);
        check("coll_old", read_data, 32'hA);
        op(2'b11, 3'b010, 32'h0, 1'b0, 32'h14, 32'h0, 5'd2);
        check("coll_new", read_data, 32'hB);
        for (int k = 0; k < 300; k++) begin
            r = $urandom();
            op(2'($urandom()), 3'($urandom()), $urandom(), 1'($urandom()),
               {r[31:10], 4'h0, 4'($urandom_range(0, 15)), r[1:0]}, $urandom(), 5'($urandom()));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
